// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset control unit:
// FSM states, opcode values, ALU function codes, datapath select
// encodings, trap causes and the branch-condition helper.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU_R,
    CL_ALU_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI
  } op_class_t;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_COPY2 = 4'd15;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  localparam logic [1:0] OP2_RS2   = 2'd0;
  localparam logic [1:0] OP2_IMM_I = 2'd1;
  localparam logic [1:0] OP2_IMM_S = 2'd2;
  localparam logic [1:0] OP2_IMM_U = 2'd3;

  localparam logic [1:0] WB_PC4 = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_ALU = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

  // Branch condition from func3 and the comparator flags (func3 2/3 never taken)
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: IR -> opcode class, rd==x0 flag,
// ALU function, operand-2 select and opcode legality.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ALUFUN_W = 4
) (
  input  logic [31:0]         ir,
  output op_class_t           op_class,
  output logic                rd_is_zero,
  output logic [ALUFUN_W-1:0] alufun,
  output logic [1:0]          op2sel,
  output logic                legal
);

  logic [2:0] f3;
  logic       f7b5;
  logic [3:0] fun4;
  logic       unused_ir;

  assign f3         = ir[14:12];
  assign f7b5       = ir[30];
  assign rd_is_zero = (ir[11:7] == 5'd0);
  assign alufun     = ALUFUN_W'(fun4);
  assign unused_ir  = ^{ir[31], ir[29:15]};

  // Classify the opcode and pick ALU function / operand-2 source
  always_comb begin
    op_class = CL_ALU_I;
    fun4     = ALU_ADD;
    op2sel   = OP2_RS2;
    legal    = 1'b1;
    case (ir[6:0])
      OPC_R: begin
        op_class = CL_ALU_R;
        fun4     = {f7b5, f3};
      end
      OPC_I: begin
        op_class = CL_ALU_I;
        op2sel   = OP2_IMM_I;
        // only the shift-right immediates carry func7[5] (SRLI vs SRAI)
        fun4     = (f3 == 3'd5) ? {f7b5, f3} : {1'b0, f3};
      end
      OPC_LOAD: begin
        op_class = CL_LOAD;
        op2sel   = OP2_IMM_I;
      end
      OPC_STORE: begin
        op_class = CL_STORE;
        op2sel   = OP2_IMM_S;
      end
      OPC_BRANCH: op_class = CL_BRANCH;
      OPC_JAL:    op_class = CL_JAL;
      OPC_JALR: begin
        op_class = CL_JALR;
        op2sel   = OP2_IMM_I;
      end
      OPC_LUI: begin
        op_class = CL_LUI;
        op2sel   = OP2_IMM_U;
        fun4     = ALU_COPY2;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset control unit: FETCH/DECODE/EXEC/MEM/WB FSM with
// a shared memory handshake and a sticky trap state.
// Optional feature: define MEM_TIMEOUT_EN to trap (cause 2) after TO_CYCLES
// consecutive FETCH/MEM cycles without mem_rdy.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int ALUFUN_W  = 4,
  parameter int TO_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         inst,
  input  logic                mem_rdy,
  input  logic                br_eq,
  input  logic                br_lt,
  input  logic                br_ltu,
  output logic                mem_val,
  output logic                mem_rw,
  output logic                ir_wen,
  output logic                pc_wen,
  output logic                rf_wen,
  output logic [1:0]          pc_sel,
  output logic                op1sel,
  output logic [1:0]          op2sel,
  output logic [1:0]          wb_sel,
  output logic [ALUFUN_W-1:0] alufun,
  output logic                retire,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  state_t              state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic [1:0]          trap_cause_q, trap_cause_d;
  op_class_t           dec_class;
  logic                dec_rd0, dec_legal;
  logic [ALUFUN_W-1:0] dec_alufun;
  logic [1:0]          dec_op2sel;
  logic                mem_wait;
  logic                to_hit;

  ctrl_decode #(.ALUFUN_W(ALUFUN_W)) u_decode (
    .ir        (ir_q),
    .op_class  (dec_class),
    .rd_is_zero(dec_rd0),
    .alufun    (dec_alufun),
    .op2sel    (dec_op2sel),
    .legal     (dec_legal)
  );

  // a FETCH/MEM cycle that ends without a handshake
  assign mem_wait = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_rdy;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  // the wait cycle that would make the count reach TO_CYCLES
  assign to_hit = mem_wait && (to_cnt_q == CNT_W'(TO_CYCLES - 1));

  // Count consecutive wait cycles; any handshake or other state clears
  always_comb begin
    to_cnt_d = '0;
    if (mem_wait && !to_hit) to_cnt_d = to_cnt_q + CNT_W'(1);
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  logic [31:0] unused_to_cycles;
  assign unused_to_cycles = 32'(TO_CYCLES);
  assign to_hit           = 1'b0;
`endif

  // Next state, IR capture and all datapath controls from state + IR
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    trap_cause_d = trap_cause_q;
    mem_val      = 1'b0;
    mem_rw       = 1'b0;
    ir_wen       = 1'b0;
    pc_wen       = 1'b0;
    rf_wen       = 1'b0;
    pc_sel       = PC_PLUS4;
    op1sel       = 1'b0;
    op2sel       = OP2_RS2;
    wb_sel       = WB_PC4;
    alufun       = '0;
    retire       = 1'b0;
    trap         = (state_q == ST_TRAP);
    trap_cause   = trap_cause_q;
    case (state_q)
      ST_FETCH: begin
        mem_val = 1'b1;
        op1sel  = 1'b1;
        if (mem_rdy) begin
          ir_wen  = 1'b1;
          ir_d    = inst;
          state_d = ST_DECODE;
        end else if (to_hit) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_ILLEGAL;
        end
      end
      ST_EXEC: begin
        op2sel = dec_op2sel;
        alufun = dec_alufun;
        case (dec_class)
          CL_BRANCH: begin
            if (ir_q[14:13] == 2'b01) begin
              state_d      = ST_TRAP;
              trap_cause_d = TRAP_ILLEGAL;
            end else begin
              pc_wen  = 1'b1;
              retire  = 1'b1;
              pc_sel  = branch_taken(ir_q[14:12], br_eq, br_lt, br_ltu) ? PC_BRANCH : PC_PLUS4;
              state_d = ST_FETCH;
            end
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        // address selects held from EXEC so they stay stable through the wait
        mem_val = 1'b1;
        mem_rw  = (dec_class == CL_STORE);
        op2sel  = dec_op2sel;
        alufun  = dec_alufun;
        if (mem_rdy) begin
          if (dec_class == CL_STORE) begin
            pc_wen  = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (to_hit) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_TIMEOUT;
        end
      end
      ST_WB: begin
        rf_wen = !dec_rd0;
        pc_wen = 1'b1;
        retire = 1'b1;
        if (dec_class == CL_LOAD)                             wb_sel = WB_MEM;
        else if (dec_class == CL_JAL || dec_class == CL_JALR) wb_sel = WB_PC4;
        else                                                  wb_sel = WB_ALU;
        if (dec_class == CL_JAL)       pc_sel = PC_JAL;
        else if (dec_class == CL_JALR) pc_sel = PC_JALR;
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
    // outputs are forced quiet for as long as reset is held
    if (!rst_n) begin
      mem_val    = 1'b0;
      mem_rw     = 1'b0;
      ir_wen     = 1'b0;
      pc_wen     = 1'b0;
      rf_wen     = 1'b0;
      pc_sel     = '0;
      op1sel     = 1'b0;
      op2sel     = '0;
      wb_sel     = '0;
      alufun     = '0;
      retire     = 1'b0;
      trap       = 1'b0;
      trap_cause = '0;
    end
  end

  // State, IR and trap-cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      ir_q         <= '0;
      trap_cause_q <= TRAP_NONE;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      trap_cause_q <= trap_cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model
// builds the expected output vector (with a care mask) for every cycle and
// one compare process checks the DUT on each falling edge.
module tb_multicycle_control;

  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0;
  logic        mem_rdy = 1'b0, br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
  logic        mem_val, mem_rw, ir_wen, pc_wen, rf_wen, op1sel, retire, trap;
  logic [1:0]  pc_sel, op2sel, wb_sel, trap_cause;
  logic [3:0]  alufun;

  multicycle_control #(.ALUFUN_W(4), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem_rdy(mem_rdy),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .mem_val(mem_val), .mem_rw(mem_rw), .ir_wen(ir_wen), .pc_wen(pc_wen),
    .rf_wen(rf_wen), .pc_sel(pc_sel), .op1sel(op1sel), .op2sel(op2sel),
    .wb_sel(wb_sel), .alufun(alufun), .retire(retire), .trap(trap),
    .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_val;
    logic       mem_rw;
    logic       ir_wen;
    logic       pc_wen;
    logic       rf_wen;
    logic [1:0] pc_sel;
    logic       op1sel;
    logic [1:0] op2sel;
    logic [1:0] wb_sel;
    logic [3:0] alufun;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;
  } outs_t;

  outs_t dut_o;
  assign dut_o = {mem_val, mem_rw, ir_wen, pc_wen, rf_wen, pc_sel, op1sel,
                  op2sel, wb_sel, alufun, retire, trap, trap_cause};

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  outs_t exp_o = '0;
  outs_t exp_m = '1;
  string ph = "reset";
  outs_t obs[$];

  // Per-cycle comparison of the DUT against the model's expectation
  always @(negedge clk) begin
    cyc++;
    total++;
    if (((dut_o ^ exp_o) & exp_m) !== '0) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h care=%h", ph, cyc, dut_o, exp_o, exp_m);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    obs.push_back(dut_o);
    @(posedge clk);
    #1;
  endtask

  task automatic setx(input string p, input outs_t e, input outs_t m);
    ph    = p;
    exp_o = e;
    exp_m = m;
  endtask

  function automatic outs_t ctrl_mask(input bit with_rw);
    outs_t m = '0;
    m.mem_val    = 1'b1;
    m.mem_rw     = with_rw;
    m.ir_wen     = 1'b1;
    m.pc_wen     = 1'b1;
    m.rf_wen     = 1'b1;
    m.retire     = 1'b1;
    m.trap       = 1'b1;
    m.trap_cause = '1;
    return m;
  endfunction

  task automatic noise();
    inst    = $urandom;
    mem_rdy = 1'($urandom_range(0, 1));
    {br_eq, br_lt, br_ltu} = 3'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    setx("reset", '0, '1);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic expect_trap(input logic [1:0] cause, input int n);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      noise();
      e = '0;
      e.trap = 1'b1;
      e.trap_cause = cause;
      setx("trap", e, ctrl_mask(1'b1));
      step();
    end
  endtask

  // One instruction from fetch to retire (or trap / forced reset in MEM).
  // fw/mw: wait cycles before mem_rdy in FETCH/MEM; br = {eq,lt,ltu}.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic [2:0] br, input int rst_mem, output bit trapped);
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] alu;
    logic [1:0] o2, wb, pce;
    bit         sel_chk, is_mem, is_st, tk;
    outs_t      e, m;
    op = ins[6:0];
    f3 = ins[14:12];
    trapped = 1'b0;
    obs.delete();
    for (int k = 0; k <= fw; k++) begin
      noise();
      mem_rdy = (k == fw);
      if (k == fw) inst = ins;
      e = '0; e.mem_val = 1'b1; e.op1sel = 1'b1; e.ir_wen = (k == fw);
      m = ctrl_mask(1'b1); m.op1sel = 1'b1;
      setx("fetch", e, m);
      step();
      if (TO_EN && k < fw && k + 1 == TO) begin
        expect_trap(2'd2, 3);
        trapped = 1'b1;
        return;
      end
    end
    noise();
    setx("decode", '0, ctrl_mask(1'b1));
    step();
    if (!(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37})) begin
      expect_trap(2'd1, 3);
      trapped = 1'b1;
      return;
    end
    sel_chk = 1'b1; alu = 4'd0; o2 = 2'd0; wb = 2'd2; pce = 2'd0; is_mem = 1'b0; is_st = 1'b0;
    case (op)
      7'h33: alu = {ins[30], f3};
      7'h13: begin o2 = 2'd1; alu = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3}; end
      7'h03: begin o2 = 2'd1; is_mem = 1'b1; wb = 2'd1; end
      7'h23: begin o2 = 2'd2; is_mem = 1'b1; is_st = 1'b1; end
      7'h37: begin o2 = 2'd3; alu = 4'd15; end
      7'h6F: begin sel_chk = 1'b0; wb = 2'd0; pce = 2'd2; end
      7'h67: begin sel_chk = 1'b0; wb = 2'd0; pce = 2'd3; end
      default: sel_chk = 1'b0;
    endcase
    noise();
    {br_eq, br_lt, br_ltu} = br;
    e = '0;
    m = ctrl_mask(1'b1);
    if (op == 7'h63) begin
      if (f3 == 3'd2 || f3 == 3'd3) begin
        setx("exec_badbr", e, m);
        step();
        expect_trap(2'd1, 3);
        trapped = 1'b1;
        return;
      end
      case (f3)
        3'd0:    tk = br[2];
        3'd1:    tk = !br[2];
        3'd4:    tk = br[1];
        3'd5:    tk = !br[1];
        3'd6:    tk = br[0];
        default: tk = !br[0];
      endcase
      e.pc_wen = 1'b1; e.retire = 1'b1; e.pc_sel = tk ? 2'd1 : 2'd0; m.pc_sel = '1;
      setx("exec_br", e, m);
      step();
      return;
    end
    if (sel_chk) begin e.op2sel = o2; e.alufun = alu; m.op2sel = '1; m.alufun = '1; end
    setx("exec", e, m);
    step();
    if (is_mem) begin
      for (int k = 0; k <= mw; k++) begin
        noise();
        mem_rdy = (k == mw);
        e = '0; m = ctrl_mask(1'b1);
        e.mem_val = 1'b1; e.mem_rw = is_st; e.op2sel = o2; e.alufun = alu;
        m.op2sel = '1; m.alufun = '1;
        if (is_st && k == mw) begin
          e.pc_wen = 1'b1; e.retire = 1'b1; e.pc_sel = 2'd0; m.pc_sel = '1;
        end
        if (k == rst_mem && k < mw) begin
          rst_n = 1'b0;
          #1;
          chk("rst_async_outputs", 32'(dut_o), 32'd0);
          setx("in_reset", '0, '1);
          step();
          rst_n = 1'b1;
          return;
        end
        setx("mem", e, m);
        step();
        if (TO_EN && k < mw && k + 1 == TO) begin
          expect_trap(2'd2, 3);
          trapped = 1'b1;
          return;
        end
      end
      if (is_st) return;
    end
    noise();
    e = '0; m = ctrl_mask(1'b1);
    e.rf_wen = (ins[11:7] != 5'd0); e.wb_sel = wb; m.wb_sel = '1;
    e.pc_wen = 1'b1; e.retire = 1'b1; e.pc_sel = pce; m.pc_sel = '1;
    setx("wb", e, m);
    step();
  endtask

  // Overall time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [6:0] bad_ops [6] = '{7'h7F, 7'h0B, 7'h2F, 7'h57, 7'h73, 7'h00};

  initial begin
    bit          tr;
    logic [31:0] ins;
    int          sel;
    do_reset();

    // ADD x3,x1,x2 with immediate memory
    run_instr(32'h002081B3, 0, 0, 3'b000, -1, tr);
    chk("add_len", obs.size(), 4);
    chk("add_irwen_c0", obs[0].ir_wen, 1);
    chk("add_rfwen_c3", obs[3].rf_wen, 1);
    chk("add_wbsel_c3", obs[3].wb_sel, 2);
    chk("add_retire_c3", obs[3].retire, 1);
    chk("add_retire_c2", obs[2].retire, 0);
    chk("add_alufun_exec", obs[2].alufun, 0);

    // SRAI x5,x5,3
    run_instr(32'h4032D293, 0, 0, 3'b000, -1, tr);
    chk("srai_alufun", obs[2].alufun, 13);
    chk("srai_op2sel", obs[2].op2sel, 1);

    // ADDI x0,x0,1: no regfile write, still retires
    run_instr(32'h00100013, 0, 0, 3'b000, -1, tr);
    chk("addi_x0_rfwen", obs[3].rf_wen, 0);
    chk("addi_x0_retire", obs[3].retire, 1);

    // LW x1,0(x2) with three MEM wait cycles
    run_instr(32'h00012083, 0, 3, 3'b000, -1, tr);
    chk("lw_len", obs.size(), 8);
    chk("lw_memval_wait", obs[4].mem_val, 1);
    chk("lw_memrw_wait", obs[4].mem_rw, 0);
    chk("lw_wbsel", obs[7].wb_sel, 1);

    // BNE taken and not taken
    run_instr(32'h00209463, 0, 0, 3'b000, -1, tr);
    chk("bne_len", obs.size(), 3);
    chk("bne_taken_pcsel", obs[2].pc_sel, 1);
    chk("bne_taken_pcwen", obs[2].pc_wen, 1);
    run_instr(32'h00209463, 1, 0, 3'b100, -1, tr);
    chk("bne_not_taken_pcsel", obs[3].pc_sel, 0);

    // JALR x1,0(x2)
    run_instr(32'h000100E7, 0, 0, 3'b000, -1, tr);
    chk("jalr_wbsel", obs[3].wb_sel, 0);
    chk("jalr_pcsel", obs[3].pc_sel, 3);

    // Illegal opcode 0x7F
    run_instr(32'h0000007F, 0, 0, 3'b000, -1, tr);
    chk("illegal_trapped", 32'(tr), 1);
    chk("illegal_trap", obs[2].trap, 1);
    chk("illegal_cause", obs[2].trap_cause, 1);
    chk("illegal_memval", obs[4].mem_val, 0);
    do_reset();

    // Reset pulse in the middle of a load's MEM wait, then normal ADD
    run_instr(32'h00012083, 0, 3, 3'b000, 1, tr);
    run_instr(32'h002081B3, 0, 0, 3'b000, -1, tr);
    chk("post_reset_add_retire", obs[3].retire, 1);

`ifdef MEM_TIMEOUT_EN
    run_instr(32'h002081B3, 10, 0, 3'b000, -1, tr);
    chk("timeout_trapped", 32'(tr), 1);
    chk("timeout_cause", obs[TO].trap_cause, 2);
    chk("timeout_memval", obs[TO].mem_val, 0);
    do_reset();
`else
    run_instr(32'h002081B3, 1000, 0, 3'b000, -1, tr);
    chk("no_timeout_trap", 32'(tr), 0);
    chk("no_timeout_memval", obs[999].mem_val, 1);
    chk("no_timeout_cause", obs[999].trap_cause, 0);
`endif

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      ins = $urandom;
      sel = $urandom_range(0, 19);
      case (sel)
        0, 1, 2:    ins[6:0] = 7'h33;
        3, 4, 5:    ins[6:0] = 7'h13;
        6, 7:       ins[6:0] = 7'h03;
        8, 9:       ins[6:0] = 7'h23;
        10, 11, 12: ins[6:0] = 7'h63;
        13:         ins[6:0] = 7'h6F;
        14:         ins[6:0] = 7'h67;
        15:         ins[6:0] = 7'h37;
        16:         ins[6:0] = bad_ops[$urandom_range(0, 5)];
        default:    ins[6:0] = 7'h13;
      endcase
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 3'($urandom), -1, tr);
      if (tr) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
